// File: rtl/tx_upconverter.sv
// tx_upconverter: buffers baseband I/Q samples, interpolates them with a
// two-stage CIC to the master clock rate and mixes them onto an NCO carrier
// for a 14-bit DAC.
module tx_upconverter #(
    parameter int CLK_HZ     = 153600000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [31:0]        tx_freq,
    input  logic [7:0]         tx_rate,
    input  logic signed [15:0] tx_real,
    input  logic signed [15:0] tx_imag,
    input  logic               tx_strobe,
    output logic               tx_req,
    output logic signed [13:0] dac_data,
    output logic               underrun,
    output logic               overflow
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int CIC_W  = 40;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]       DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [63:0]       CLK_W    = 64'(CLK_HZ);
    localparam logic signed [15:0] S16_MAX = 16'sd32767;
    localparam logic signed [15:0] S16_MIN = -16'sd32767 - 16'sd1;
    localparam logic signed [13:0] DAC_MAX = 14'sd8191;
    localparam logic signed [13:0] DAC_MIN = -14'sd8191 - 14'sd1;

    function automatic logic signed [DATA_W-1:0] sat_cic(input logic signed [CIC_W-1:0] v);
        if (v > 40'sd32767)
            return S16_MAX;
        else if (v < -40'sd32768)
            return S16_MIN;
        return DATA_W'(v);
    endfunction

    function automatic logic signed [13:0] sat_dac(input logic signed [32:0] v);
        if (v > 33'sd8191)
            return DAC_MAX;
        else if (v < -33'sd8192)
            return DAC_MIN;
        return 14'(v);
    endfunction

    function automatic logic signed [32:0] mix(input logic signed [DATA_W-1:0] i_v, q_v,
                                               input logic signed [COEF_W-1:0] c_v, s_v);
        logic signed [32:0] p_ic;
        logic signed [32:0] p_qs;
        p_ic = 33'(i_v) * 33'(c_v);
        p_qs = 33'(q_v) * 33'(s_v);
        return p_ic - p_qs;
    endfunction

    function automatic int sin_val(input int k);
        real a;
        real v;
        a = 2.0 * 3.14159265358979323846 * real'(k) / 1024.0;
        v = 32767.0 * $sin(a);
        if (v >= 0.0)
            return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

    // Quarter-free full sine table built at elaboration
    logic signed [COEF_W-1:0] sin_lut [1024];
    for (genvar k = 0; k < 1024; k++) begin : g_lut
        localparam int V = sin_val(k);
        assign sin_lut[k] = COEF_W'(V);
    end

    logic [63:0] tune_num;
    logic [31:0] tune_inc;
    assign tune_num = {tx_freq, 32'd0} + (CLK_W >> 1);
    assign tune_inc = 32'(tune_num / CLK_W);

    logic [11:0] r_dec, r_q, cnt;
    logic [3:0]  s_dec, s_q;
    logic        rate_chg, tick;

    // Decode interpolation ratio and output shift from the rate code
    always_comb begin
        r_dec = 12'd3200;
        s_dec = 4'd12;
        case (tx_rate)
            8'd1:    begin r_dec = 12'd1600; s_dec = 4'd11; end
            8'd2:    begin r_dec = 12'd800;  s_dec = 4'd10; end
            default: ;
        endcase
    end

    assign rate_chg = (r_dec != r_q);
    assign tick     = !rate_chg && (cnt == r_q - 12'd1);

    // Active rate register and tick counter; a new rate restarts the count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= 12'd3200;
            s_q <= 4'd12;
            cnt <= '0;
        end else begin
            r_q <= r_dec;
            s_q <= s_dec;
            if (rate_chg || tick)
                cnt <= '0;
            else
                cnt <= cnt + 12'd1;
        end
    end

    logic signed [DATA_W-1:0] mem_i [FIFO_DEPTH];
    logic signed [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, pop, push, ready_q;

    assign full   = (count == DEPTH_C);
    assign empty  = (count == '0);
    assign pop    = tick && !empty;
    assign push   = tx_strobe && (!full || pop);
    assign tx_req = ready_q && !full;

    // Sample storage, written on accepted strobes
    always_ff @(posedge clock) begin
        if (push) begin
            mem_i[wr_ptr] <= tx_real;
            mem_q[wr_ptr] <= tx_imag;
        end
    end

    // FIFO pointers, occupancy, request enable and sticky error flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_q  <= 1'b0;
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
                2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
                default: ;
            endcase
            if (tx_strobe && !push)
                overflow <= 1'b1;
            if (tick && empty)
                underrun <= 1'b1;
        end
    end

    logic signed [CIC_W-1:0] x_i, x_q;
    assign x_i = pop ? CIC_W'(mem_i[rd_ptr]) : '0;
    assign x_q = pop ? CIC_W'(mem_q[rd_ptr]) : '0;

    logic signed [CIC_W-1:0] xd_i, xd_q, c1_i_p0, c1_q_p0;
    logic signed [CIC_W-1:0] c1d_i, c1d_q, c2_i_p1, c2_q_p1;
    logic signed [CIC_W-1:0] int1_i_p2, int1_q_p2, int2_i_p3, int2_q_p3;
    logic                    vld_p0, vld_p1;

    // Stage 0: first comb, evaluated on each tick with the popped (or zero) sample
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n || !reset_n) begin
            vld_p0  <= 1'b0;
            xd_i    <= '0;
            xd_q    <= '0;
            c1_i_p0 <= '0;
            c1_q_p0 <= '0;
        end else if (rate_chg) begin
            vld_p0  <= 1'b0;
            xd_i    <= '0;
            xd_q    <= '0;
            c1_i_p0 <= '0;
            c1_q_p0 <= '0;
        end else begin
            vld_p0 <= tick;
            if (tick) begin
                c1_i_p0 <= x_i - xd_i;
                c1_q_p0 <= x_q - xd_q;
                xd_i    <= x_i;
                xd_q    <= x_q;
            end
        end
    end

    // Stage 1: second comb on the comb-1 output of the previous tick
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            c1d_i   <= '0;
            c1d_q   <= '0;
            c2_i_p1 <= '0;
            c2_q_p1 <= '0;
        end else if (rate_chg) begin
            vld_p1  <= 1'b0;
            c1d_i   <= '0;
            c1d_q   <= '0;
            c2_i_p1 <= '0;
            c2_q_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                c2_i_p1 <= c1_i_p0 - c1d_i;
                c2_q_p1 <= c1_q_p0 - c1d_q;
                c1d_i   <= c1_i_p0;
                c1d_q   <= c1_q_p0;
            end
        end
    end

    // Stage 2: first integrator, fed zero between ticks (zero stuffing)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            int1_i_p2 <= '0;
            int1_q_p2 <= '0;
        end else if (rate_chg) begin
            int1_i_p2 <= '0;
            int1_q_p2 <= '0;
        end else if (vld_p1) begin
            int1_i_p2 <= int1_i_p2 + c2_i_p1;
            int1_q_p2 <= int1_q_p2 + c2_q_p1;
        end
    end

    // Stage 3: second integrator
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            int2_i_p3 <= '0;
            int2_q_p3 <= '0;
        end else if (rate_chg) begin
            int2_i_p3 <= '0;
            int2_q_p3 <= '0;
        end else begin
            int2_i_p3 <= int2_i_p3 + int1_i_p2;
            int2_q_p3 <= int2_q_p3 + int1_q_p2;
        end
    end

    logic [31:0]              phase_q;
    logic signed [DATA_W-1:0] cic_i, cic_q;
    logic signed [COEF_W-1:0] sin_v, cos_v;
    logic signed [32:0]       y_p4;

    assign cic_i = sat_cic(int2_i_p3 >>> s_q);
    assign cic_q = sat_cic(int2_q_p3 >>> s_q);
    assign sin_v = sin_lut[phase_q[31:22]];
    assign cos_v = sin_lut[phase_q[31:22] + 10'd256];

    // Phase accumulator, continuous across frequency changes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            phase_q <= '0;
        else
            phase_q <= phase_q + tune_inc;
    end

    // Stage 4: complex mix of the scaled CIC output with the carrier
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            y_p4 <= '0;
        else
            y_p4 <= mix(cic_i, cic_q, cos_v, sin_v);
    end

    // Stage 5: scale and saturate to the DAC range
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            dac_data <= '0;
        else
            dac_data <= sat_dac(y_p4 >>> 18);
    end

endmodule

// File: tb/tb_tx_upconverter.sv
// tb_tx_upconverter: directed checks of reset, DC gain and latency, FIFO
// overflow/underrun, carrier tone and rate change for tx_upconverter.
module tb_tx_upconverter;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic [31:0]        tx_freq = '0;
    logic [7:0]         tx_rate = '0;
    logic signed [15:0] tx_real = '0;
    logic signed [15:0] tx_imag = '0;
    logic               tx_strobe = 1'b0;
    logic               tx_req;
    logic signed [13:0] dac_data;
    logic               underrun;
    logic               overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic feed = 1'b0;

    int mx, mn, t1, t2, ncross;
    logic signed [13:0] prev;

    localparam int R0 = 3200;
    localparam int R2 = 800;
    localparam int C  = 6450;

    tx_upconverter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .tx_freq   (tx_freq),
        .tx_rate   (tx_rate),
        .tx_real   (tx_real),
        .tx_imag   (tx_imag),
        .tx_strobe (tx_strobe),
        .tx_req    (tx_req),
        .dac_data  (dac_data),
        .underrun  (underrun),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge; outputs sampled 1ns later, feeder answers tx_req
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        tx_strobe = feed && tx_req;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic release_reset();
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic mid_reset();
        #2;
        reset_n   = 1'b0;
        feed      = 1'b0;
        tx_strobe = 1'b0;
        #1;
        check("arst_dac", dac_data, 0);
        check("arst_txreq", tx_req, 0);
    endtask

    initial begin
        // Power-up reset
        repeat (10) @(posedge clock);
        #1;
        check("rst_dac", dac_data, 0);
        check("rst_underrun", underrun, 0);
        check("rst_overflow", overflow, 0);
        check("rst_txreq", tx_req, 0);
        @(negedge clock);
        reset_n = 1'b1;
        cyc = 0;

        // DC at rate 0: latency ramp and settled value
        tx_real = 16'sd16384;
        tx_imag = 16'sd0;
        feed    = 1'b1;
        step();
        check("rel_txreq", tx_req, 1);
        run_to(R0 + 6);
        check("dc_lat_r6", dac_data, 0);
        step();
        check("dc_lat_r7", dac_data, 1);
        step();
        check("dc_lat_r8", dac_data, 1);
        run_to(2 * R0 + 10);
        check("dc_settle", dac_data, 1599);
        check("dc_underrun", underrun, 0);
        check("dc_overflow", overflow, 0);

        // Reset mid-stream discards everything
        mid_reset();
        release_reset();

        // Overflow: five back-to-back strobes into a 4-deep FIFO
        step();
        check("ovf_txreq_rel", tx_req, 1);
        for (int i = 0; i < 5; i++) begin
            tx_strobe = 1'b1;
            step();
            if (i == 3) begin
                check("ovf_txreq_full", tx_req, 0);
                check("ovf_flag_4th", overflow, 0);
            end
        end
        check("ovf_flag_5th", overflow, 1);

        // Underrun after the four stored samples drain
        run_to(5 * R0 - 1);
        check("unf_pre_flag", underrun, 0);
        check("unf_pre_dac", dac_data, 1599);
        step();
        check("unf_flag", underrun, 1);
        run_to(7 * R0 + 6);
        check("unf_decay", dac_data, 0);

        // Tone at 48 kHz
        mid_reset();
        tx_freq = 32'd48000;
        tx_rate = 8'd0;
        release_reset();
        feed = 1'b1;
        run_to(2 * R0 + 20);
        mx = -100000;
        mn = 100000;
        ncross = 0;
        t1 = 0;
        t2 = 0;
        prev = dac_data;
        for (int k = 0; k < 8000; k++) begin
            step();
            if (dac_data > mx) mx = dac_data;
            if (dac_data < mn) mn = dac_data;
            if (prev < 0 && dac_data >= 0) begin
                ncross++;
                if (ncross == 1) t1 = cyc;
                else if (ncross == 2) t2 = cyc;
            end
            prev = dac_data;
        end
        check("tone_max", mx, 1599);
        check("tone_min", mn, -1600);
        check("tone_period_3200", ((t2 - t1 == 3200) || (t2 - t1 == 3201)), 1);
        check("tone_underrun", underrun, 0);

        // Rate change 0 -> 2 with a full FIFO
        mid_reset();
        tx_freq = 32'd0;
        tx_rate = 8'd0;
        release_reset();
        feed = 1'b1;
        run_to(C - 1);
        check("rc_pre_dac", dac_data, 1599);
        tx_rate = 8'd2;
        step();
        check("rc_fifo_kept", tx_req, 0);
        run_to(C + 4);
        check("rc_cleared", dac_data, 0);
        run_to(C + R2 + 4);
        check("rc_lat_r4", dac_data, 0);
        step();
        check("rc_lat_r5", dac_data, 1);
        step();
        check("rc_lat_r6", dac_data, 3);
        run_to(C + 2 * R2 + 10);
        check("rc_settle", dac_data, 1599);
        check("rc_underrun", underrun, 0);
        check("rc_overflow", overflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_upconverter.md
TX_UPCONVERTER -- requirements
Module: tx_upconverter

Interface
REQ-001 Parameter CLK_HZ, default 153600000, master clock rate used to derive tune phase.
REQ-002 Parameter FIFO_DEPTH, default 4, input sample buffer depth (power of two).
REQ-003 clock  input  1  master clock, all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 tx_freq  input  32  carrier frequency in Hz, unsigned.
REQ-006 tx_rate  input  8  baseband rate code: 0=48k, 1=96k, 2=192k, other=48k.
REQ-007 tx_real, tx_imag  input  16 each  signed baseband I/Q sample.
REQ-008 tx_strobe  input  1  one-cycle write of tx_real/tx_imag into FIFO.
REQ-009 tx_req  output  1  level, high while FIFO not full.
REQ-010 dac_data  output  14  signed DAC sample, updated every clock.
REQ-011 underrun, overflow  output  1 each  sticky error flags.

Function
REQ-012 Interpolation R SHALL decode from tx_rate: 0->3200, 1->1600, 2->800, other->3200; shift S = 12, 11, 10 respectively.
REQ-013 Tune phase SHALL equal round(tx_freq * 2^32 / CLK_HZ), recomputed combinationally, no registered latency requirement.
REQ-014 Tick counter SHALL count 0..R-1 every clock; tick asserted one cycle when count = R-1.
REQ-015 FIFO write on tx_strobe when not full; write when full SHALL be dropped and set overflow.
REQ-016 Simultaneous write and pop in one cycle SHALL both succeed, including when full (pop frees slot) and when empty (no: empty pop is underrun, write stored).
REQ-017 On tick, FIFO non-empty: pop oldest I/Q pair; FIFO empty: use 0/0 and set underrun.
REQ-018 CIC per channel: 2 combs (differential delay 1) updated on tick, zero-stuffed to clock rate, 2 integrators updated every clock; 40-bit signed two's-complement, wrap on overflow.
REQ-019 CIC output = integrator2 >>> S, saturated to 16-bit signed; steady-state DC gain R/2^S = 0.78125 for all rates.
REQ-020 Phase accumulator 32-bit, += tune phase every clock, wraps modulo 2^32.
REQ-021 Sine table 1024 entries, index phase[31:22], value round(32767*sin(2*pi*k/1024)); cos = entry (k+256) mod 1024.
REQ-022 Mixer: y = I*cos - Q*sin, 33-bit signed; dac_data = (y >>> 18) saturated to [-8192, 8191].
REQ-023 Latency SHALL be 6 clocks from tick to first dac_data change caused by the popped sample.
REQ-024 Change of decoded R SHALL clear combs, integrators and tick counter next cycle; FIFO and phase accumulator preserved.
REQ-025 tx_freq change SHALL affect increment next clock with no phase reset (phase-continuous).

Reset
REQ-026 reset_n low SHALL asynchronously clear FIFO (empty), tick counter, CIC state, phase accumulator, pipeline registers.
REQ-027 During reset: dac_data=0, underrun=0, overflow=0, tx_req=0; tx_req=1 first clock after release.
REQ-028 Sticky flags clear only by reset.
REQ-029 Reset asserted mid-operation SHALL discard all buffered samples; no partial sample emitted after release.

Verification
REQ-030 Reset: hold reset_n low 10 clocks -> dac_data=0, flags 0; release -> tx_req=1 next clock.
REQ-031 DC: tx_freq=0, tx_rate=0, I=16384, Q=0 fed each tx_req -> dac_data settles to 1599 after 2R+6 clocks, no flags.
REQ-032 Overflow: after reset, 5 strobes on consecutive clocks before first tick -> tx_req low after 4th, overflow=1, 5th sample never appears.
REQ-033 Underrun: stop strobes with FIFO draining -> underrun=1 on first empty tick, CIC input 0, dac_data decays to 0 within 2R+6 clocks.
REQ-034 Tone: tx_freq=48000, rate 0, I=16384 -> phase increment 1342177, dac_data sinusoid period 3200 clocks, peak 1599 +/-1.
REQ-035 Rate change: tx_rate 0->2 mid-stream -> CIC state cleared, ticks every 800 clocks, DC output returns to 1599, FIFO contents intact.
